// File: rtl/snake_head_ctrl.sv
// Snake head movement controller: steps the head on each tick, pushes it into the
// body FIFO, pops and reports the tail unless growing, tracks length and wall hits.
module snake_head_ctrl #(
  parameter  int unsigned MAX_LEN = 128,
  parameter  int unsigned WRAP    = 0,
  localparam int unsigned POS_W   = 8,
  localparam int unsigned LEN_W   = 8,
  localparam int unsigned CRD_W   = 4,
  localparam int unsigned DIR_W   = 2
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             start,
  input  logic             tick,
  input  logic [DIR_W-1:0] dir_in,
  input  logic             dir_valid,
  input  logic             grow,
  input  logic [POS_W-1:0] fifo_dataout,
  output logic             fifo_wrenable,
  output logic             fifo_rdenable,
  output logic [POS_W-1:0] fifo_datain,
  output logic [POS_W-1:0] head_pos,
  output logic [POS_W-1:0] tail_pos,
  output logic             tail_valid,
  output logic [LEN_W-1:0] length,
  output logic             game_over
);

  localparam bit WRAP_EN = (WRAP != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PUSH,
    S_CAPTURE,
    S_OVER
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [DIR_W-1:0]   r_dir;
  logic [DIR_W-1:0]   r_dir_req;
  logic               r_grow_pending;
  logic               r_popped;

  logic               w_dir_ok;
  logic [DIR_W-1:0]   w_dir_eff;
  logic               w_growing;
  logic               w_tick_ok;
  logic               w_step;
  logic               w_wall;
  logic [CRD_W:0]     w_nx;
  logic [CRD_W:0]     w_ny;
  logic [POS_W-1:0]   w_new_head;

  // A same-cycle request overrides the stored one; reversals are never accepted
  assign w_dir_ok  = dir_valid && (dir_in != (r_dir ^ 2'b10));
  assign w_dir_eff = w_dir_ok ? dir_in : r_dir_req;
  assign w_growing = (r_grow_pending || grow) && (length < LEN_W'(MAX_LEN));
  assign w_tick_ok = (r_state == S_RUN) && tick;
  assign w_step    = w_tick_ok && !w_wall;

  // Next head with one guard bit per coordinate to catch under/overflow
  always_comb begin
    w_nx = {1'b0, head_pos[CRD_W-1:0]};
    w_ny = {1'b0, head_pos[POS_W-1:CRD_W]};
    unique case (w_dir_eff)
      2'b00:   w_nx = {1'b0, head_pos[CRD_W-1:0]} + (CRD_W+1)'(1);
      2'b01:   w_ny = {1'b0, head_pos[POS_W-1:CRD_W]} + (CRD_W+1)'(1);
      2'b10:   w_nx = {1'b0, head_pos[CRD_W-1:0]} - (CRD_W+1)'(1);
      default: w_ny = {1'b0, head_pos[POS_W-1:CRD_W]} - (CRD_W+1)'(1);
    endcase
    w_wall     = !WRAP_EN && (w_nx[CRD_W] || w_ny[CRD_W]);
    w_new_head = {w_ny[CRD_W-1:0], w_nx[CRD_W-1:0]};
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:    if (start) w_state_next = S_RUN;
      S_RUN:     if (tick)  w_state_next = w_wall ? S_OVER : S_PUSH;
      S_PUSH:    w_state_next = S_CAPTURE;
      S_CAPTURE: w_state_next = S_RUN;
      S_OVER:    w_state_next = S_OVER;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Direction and grow bookkeeping
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_dir          <= 2'b00;
      r_dir_req      <= 2'b00;
      r_grow_pending <= 1'b0;
    end else begin
      if (w_step) begin
        r_dir     <= w_dir_eff;
        r_dir_req <= w_dir_eff;
      end else if (w_dir_ok) begin
        r_dir_req <= dir_in;
      end
      if (w_step)    r_grow_pending <= 1'b0;
      else if (grow) r_grow_pending <= 1'b1;
    end
  end

  // Registered outputs: strobes for one cycle after the step, tail two cycles later
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      fifo_wrenable <= 1'b0;
      fifo_rdenable <= 1'b0;
      fifo_datain   <= '0;
      head_pos      <= POS_W'(8'h02);
      tail_pos      <= '0;
      tail_valid    <= 1'b0;
      length        <= LEN_W'(3);
      game_over     <= 1'b0;
      r_popped      <= 1'b0;
    end else begin
      fifo_wrenable <= w_step;
      fifo_rdenable <= w_step && !w_growing;
      tail_valid    <= 1'b0;
      if (w_step) begin
        fifo_datain <= w_new_head;
        head_pos    <= w_new_head;
        r_popped    <= !w_growing;
        if (w_growing) length <= length + LEN_W'(1);
      end
      if ((r_state == S_CAPTURE) && r_popped) begin
        tail_pos   <= fifo_dataout;
        tail_valid <= 1'b1;
      end
      if (w_tick_ok && w_wall) game_over <= 1'b1;
    end
  end

endmodule
